// File: rtl/xoodoo_perm_sca_pkg.sv
// Shared types and constants for the masked Xoodoo permutation controller.
// Holds the FSM encoding, widths and the round-constant table.
package xoodoo_sca_pkg;

  localparam int STATE_W     = 384;
  localparam int LANE_W      = 32;
  localparam int NROUNDS_MAX = 12;
  localparam int RC_W        = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } perm_state_t;

  // Entry 0 sits in the least significant slot, so RC_TABLE[i] is round constant i.
  localparam logic [NROUNDS_MAX-1:0][RC_W-1:0] RC_TABLE = {
    12'h012, 12'h1A0, 12'h0F0, 12'h380, 12'h02C, 12'h060,
    12'h014, 12'h120, 12'h0D0, 12'h3C0, 12'h038, 12'h058
  };

endpackage

// File: rtl/xoodoo_perm_sca_if.sv
// Upstream-facing bus of the permutation controller: state in, randomness in, result out.
// The mode logic / PRNG side uses master, the controller uses slave.
interface xoodoo_perm_sca_if;
  import xoodoo_sca_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_0;
  logic [STATE_W-1:0] in_1;
  logic               rnd_valid;
  logic               rnd_ready;
  logic [STATE_W-1:0] rnd;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_0;
  logic [STATE_W-1:0] out_1;
  logic               busy;

  modport master (
    output in_valid, in_0, in_1, rnd_valid, rnd, out_ready,
    input  in_ready, rnd_ready, out_valid, out_0, out_1, busy
  );

  modport slave (
    input  in_valid, in_0, in_1, rnd_valid, rnd, out_ready,
    output in_ready, rnd_ready, out_valid, out_0, out_1, busy
  );

endinterface

// File: rtl/xoodoo_perm_sca_rc_rom.sv
// Combinational round-constant lookup, zero-extended to a full lane.
// Indices past the table return zero.
module xoodoo_rc_rom
  import xoodoo_sca_pkg::*;
(
  input  logic [3:0]        idx,
  output logic [LANE_W-1:0] rconst
);

  always_comb begin
    rconst = '0;
    if (idx < 4'(NROUNDS_MAX)) begin
      rconst = {{(LANE_W-RC_W){1'b0}}, RC_TABLE[idx]};
    end
  end

endmodule

// File: rtl/xoodoo_perm_sca.sv
// Sequencing controller for the DOM-masked Xoodoo permutation: drives an external
// round datapath once per round and feeds its registered output back as the next input.
module xoodoo_perm_sca
  import xoodoo_sca_pkg::*;
#(
  parameter int unsigned NROUNDS = 12
) (
  input  logic               clk,
  input  logic               rst,
  xoodoo_perm_sca_if.slave   bus,
  output logic [STATE_W-1:0] rd_in_0,
  output logic [STATE_W-1:0] rd_in_1,
  output logic [STATE_W-1:0] rd_rdi,
  output logic               rd_rdi_en,
  output logic [LANE_W-1:0]  rd_rconst,
  input  logic [STATE_W-1:0] rd_out_0,
  input  logic [STATE_W-1:0] rd_out_1
);

  localparam logic [3:0] RC_BASE = 4'(NROUNDS_MAX - NROUNDS);
  localparam logic [3:0] LAST_RC = 4'(NROUNDS - 1);

  perm_state_t       state_q, state_d;
  logic [3:0]        rc_q, rc_d;
  logic [3:0]        rom_idx;
  logic [LANE_W-1:0] rom_const;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  // Outputs are held at their idle values while rst is high so nothing leaks before the first live cycle.
  always_comb begin
    state_d       = state_q;
    rc_d          = rc_q;
    bus.in_ready  = 1'b0;
    bus.rnd_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    rd_rdi_en     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          bus.in_ready = bus.rnd_valid;
          if (bus.in_valid && bus.rnd_valid) begin
            bus.rnd_ready = 1'b1;
            rd_rdi_en     = 1'b1;
            rc_d          = 4'd1;
            state_d       = (NROUNDS == 1) ? DONE : ROUND;
          end
        end
        ROUND: begin
          bus.busy      = 1'b1;
          bus.rnd_ready = bus.rnd_valid;
          rd_rdi_en     = bus.rnd_valid;
          if (bus.rnd_valid) begin
            if (rc_q == LAST_RC) begin
              state_d = DONE;
              rc_d    = '0;
            end else begin
              rc_d = rc_q + 4'd1;
            end
          end
        end
        DONE: begin
          bus.busy      = 1'b1;
          bus.out_valid = 1'b1;
          if (bus.out_ready) begin
            state_d = IDLE;
            rc_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          rc_d    = '0;
        end
      endcase
    end
  end

  assign rom_idx = RC_BASE + rc_q;

  xoodoo_rc_rom u_rc_rom (
    .idx    (rom_idx),
    .rconst (rom_const)
  );

  // Shares stay separate end to end; only the mux source changes between load and feedback.
  assign rd_in_0   = (state_q == IDLE) ? bus.in_0 : rd_out_0;
  assign rd_in_1   = (state_q == IDLE) ? bus.in_1 : rd_out_1;
  assign rd_rdi    = bus.rnd;
  assign rd_rconst = rd_rdi_en ? rom_const : '0;
  assign bus.out_0 = rd_out_0;
  assign bus.out_1 = rd_out_1;

endmodule

// File: tb/tb_xoodoo_perm_sca.sv
// Self-checking bench for xoodoo_perm_sca with a behavioural stand-in for the round datapath
// and a plain-arithmetic Xoodoo reference permutation.
module tb_xoodoo_perm_sca;
  import xoodoo_sca_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [31:0] rc_ref [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                               32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

  xoodoo_perm_sca_if bus12 ();
  xoodoo_perm_sca_if bus6 ();

  logic [383:0] rd_in_0_12, rd_in_1_12, rd_rdi_12, rd_out_0_12, rd_out_1_12;
  logic         rd_rdi_en_12;
  logic [31:0]  rd_rconst_12;
  logic [383:0] rd_in_0_6, rd_in_1_6, rd_rdi_6, rd_out_0_6, rd_out_1_6;
  logic         rd_rdi_en_6;
  logic [31:0]  rd_rconst_6;

  xoodoo_perm_sca #(.NROUNDS(12)) u_dut12 (
    .clk(clk), .rst(rst), .bus(bus12),
    .rd_in_0(rd_in_0_12), .rd_in_1(rd_in_1_12), .rd_rdi(rd_rdi_12),
    .rd_rdi_en(rd_rdi_en_12), .rd_rconst(rd_rconst_12),
    .rd_out_0(rd_out_0_12), .rd_out_1(rd_out_1_12)
  );

  xoodoo_perm_sca #(.NROUNDS(6)) u_dut6 (
    .clk(clk), .rst(rst), .bus(bus6),
    .rd_in_0(rd_in_0_6), .rd_in_1(rd_in_1_6), .rd_rdi(rd_rdi_6),
    .rd_rdi_en(rd_rdi_en_6), .rd_rconst(rd_rconst_6),
    .rd_out_0(rd_out_0_6), .rd_out_1(rd_out_1_6)
  );

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // One unmasked Xoodoo round on planes y=0..2, lanes x=0..3 (lane 4*y+x at bits 32*(4*y+x)).
  function automatic logic [383:0] xround(input logic [383:0] s, input logic [31:0] rc);
    logic [31:0]  a [12];
    logic [31:0]  b [12];
    logic [31:0]  p [4];
    logic [31:0]  e [4];
    logic [31:0]  t [4];
    logic [383:0] r;
    for (int i = 0; i < 12; i++) a[i] = s[32*i +: 32];
    for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[4+x] ^ a[8+x];
    for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int i = 0; i < 12; i++) a[i] = a[i] ^ e[i%4];
    for (int x = 0; x < 4; x++) t[x] = a[4+x];
    for (int x = 0; x < 4; x++) begin
      a[4+x] = t[(x+3)%4];
      a[8+x] = rotl(a[8+x], 11);
    end
    a[0] = a[0] ^ rc;
    for (int x = 0; x < 4; x++) begin
      b[x]   = ~a[4+x] & a[8+x];
      b[4+x] = ~a[8+x] & a[x];
      b[8+x] = ~a[x]   & a[4+x];
    end
    for (int i = 0; i < 12; i++) a[i] = a[i] ^ b[i];
    for (int x = 0; x < 4; x++) t[x] = a[8+x];
    for (int x = 0; x < 4; x++) begin
      a[4+x] = rotl(a[4+x], 1);
      a[8+x] = rotl(t[(x+2)%4], 8);
    end
    for (int i = 0; i < 12; i++) r[32*i +: 32] = a[i];
    return r;
  endfunction

  function automatic logic [383:0] perm(input logic [383:0] s, input int n);
    logic [383:0] st;
    st = s;
    for (int i = 0; i < n; i++) st = xround(st, rc_ref[12-n+i]);
    return st;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Stand-in round datapaths: the output is re-split with the fresh randomness as the second share.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_out_0_12 <= '0;
      rd_out_1_12 <= '0;
    end else if (rd_rdi_en_12) begin
      rd_out_0_12 <= xround(rd_in_0_12 ^ rd_in_1_12, rd_rconst_12) ^ rd_rdi_12;
      rd_out_1_12 <= rd_rdi_12;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_out_0_6 <= '0;
      rd_out_1_6 <= '0;
    end else if (rd_rdi_en_6) begin
      rd_out_0_6 <= xround(rd_in_0_6 ^ rd_in_1_6, rd_rconst_6) ^ rd_rdi_6;
      rd_out_1_6 <= rd_rdi_6;
    end
  end

  task automatic check_output(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one 12-round permutation from the drive phase of an IDLE cycle, back to the drive phase in IDLE.
  task automatic apply_stimulus(input string name, input logic [383:0] s0, input logic [383:0] s1,
                                input logic zero_rnd, input int stall_at, input int stall_len,
                                input int hold, input int exp_lat, output logic [383:0] res);
    int           done_rounds, dut_lat, pulses;
    logic         exp_ready, exp_out;
    logic [31:0]  exp_rc;
    logic [383:0] exp_res, held0, held1, o0, o1;
    exp_res = perm(s0 ^ s1, 12);
    done_rounds = 0; dut_lat = -1; pulses = 0;
    held0 = '0; held1 = '0; o0 = '0; o1 = '0;
    bus12.in_0 = s0;
    bus12.in_1 = s1;
    bus12.out_ready = 1'b0;
    for (int k = 0; k < 64; k++) begin
      bus12.in_valid  = (k == 0);
      bus12.rnd_valid = !(k >= stall_at && k < stall_at + stall_len);
      bus12.rnd       = zero_rnd ? '0 : rand384();
      @(negedge clk);
      exp_out   = (done_rounds == 12);
      exp_ready = !exp_out && bus12.rnd_valid;
      exp_rc    = exp_ready ? rc_ref[done_rounds] : 32'h0;
      if (k == 0) check_output({name, "/in_ready"}, bus12.in_ready, 1);
      check_output({name, "/rnd_ready"}, bus12.rnd_ready, exp_ready);
      check_output({name, "/rdi_en"}, rd_rdi_en_12, exp_ready);
      check_output({name, "/rconst"}, rd_rconst_12, exp_rc);
      check_output({name, "/out_valid"}, bus12.out_valid, exp_out);
      if (!exp_out) check_output({name, "/rc"}, u_dut12.rc_q, done_rounds);
      if (bus12.rnd_ready) pulses++;
      if (bus12.out_valid && dut_lat < 0) dut_lat = k;
      if (stall_len > 0 && k == stall_at) begin
        held0 = rd_out_0_12;
        held1 = rd_out_1_12;
      end
      if (stall_len > 0 && k > stall_at && k <= stall_at + stall_len) begin
        check_output({name, "/stall_hold0"}, rd_out_0_12, held0);
        check_output({name, "/stall_hold1"}, rd_out_1_12, held1);
      end
      if (exp_ready) done_rounds++;
      if (exp_out) begin
        o0 = bus12.out_0;
        o1 = bus12.out_1;
        break;
      end
      @(posedge clk); #1;
    end
    res = o0 ^ o1;
    check_output({name, "/result"}, res, exp_res);
    check_output({name, "/latency"}, dut_lat, exp_lat);
    if (hold > 0) begin
      bus12.in_valid  = 1'b1;
      bus12.rnd_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus12.rnd_ready) pulses++;
      check_output({name, "/hold_valid"}, bus12.out_valid, 1);
      check_output({name, "/hold_in_ready"}, bus12.in_ready, 0);
      check_output({name, "/hold_out0"}, bus12.out_0, o0);
      check_output({name, "/hold_out1"}, bus12.out_1, o1);
    end
    bus12.in_valid  = 1'b0;
    bus12.rnd_valid = 1'b1;
    bus12.out_ready = 1'b1;
    @(posedge clk); #1;
    bus12.out_ready = 1'b0;
    @(negedge clk);
    check_output({name, "/release_valid"}, bus12.out_valid, 0);
    check_output({name, "/release_busy"}, bus12.busy, 0);
    check_output({name, "/release_in_ready"}, bus12.in_ready, 1);
    check_output({name, "/rnd_pulses"}, pulses, 12);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string name;
    logic  zero_state;
    logic  zero_rnd;
    int    stall_at;
    int    stall_len;
    int    hold;
    int    exp_lat;
  } vec_t;

  vec_t         vecs [4];
  logic [383:0] results [4];
  logic [383:0] fixed_state, s0, s1, res;
  int           lat6;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    vecs[0] = '{"zero_state", 1'b1, 1'b1, -1, 0, 0, 12};
    vecs[1] = '{"no_stall",   1'b0, 1'b0, -1, 0, 0, 12};
    vecs[2] = '{"stall_r5",   1'b0, 1'b0,  5, 3, 0, 15};
    vecs[3] = '{"hold_done",  1'b0, 1'b0, -1, 0, 10, 12};
    fixed_state = rand384();

    rst = 1'b1;
    bus12.in_valid = 1'b1; bus12.rnd_valid = 1'b1; bus12.out_ready = 1'b0;
    bus12.in_0 = '0; bus12.in_1 = '0; bus12.rnd = '0;
    bus6.in_valid = 1'b0; bus6.rnd_valid = 1'b1; bus6.out_ready = 1'b0;
    bus6.in_0 = '0; bus6.in_1 = '0; bus6.rnd = '0;

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_output("reset/in_ready", bus12.in_ready, 0);
    check_output("reset/out_valid", bus12.out_valid, 0);
    check_output("reset/busy", bus12.busy, 0);
    check_output("reset/rnd_ready", bus12.rnd_ready, 0);
    check_output("reset/rdi_en", rd_rdi_en_12, 0);
    check_output("reset/rconst", rd_rconst_12, 0);
    check_output("reset/rc", u_dut12.rc_q, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus12.in_valid = 1'b0;

    // PRNG not ready: an offered state must not be taken.
    bus12.in_valid  = 1'b1;
    bus12.rnd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("no_rnd/in_ready", bus12.in_ready, 0);
      check_output("no_rnd/rnd_ready", bus12.rnd_ready, 0);
      check_output("no_rnd/rdi_en", rd_rdi_en_12, 0);
      check_output("no_rnd/busy", bus12.busy, 0);
      @(posedge clk); #1;
    end
    bus12.in_valid  = 1'b0;
    bus12.rnd_valid = 1'b1;

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].zero_state) begin
        s0 = '0;
        s1 = '0;
      end else begin
        s0 = rand384();
        s1 = s0 ^ fixed_state;
      end
      apply_stimulus(vecs[i].name, s0, s1, vecs[i].zero_rnd, vecs[i].stall_at,
                     vecs[i].stall_len, vecs[i].hold, vecs[i].exp_lat, res);
      results[i] = res;
    end
    check_output("stall_vs_nostall", results[2], results[1]);

    for (int v = 0; v < 100; v++) begin
      s0 = rand384();
      apply_stimulus("rand", s0, s0 ^ fixed_state, 1'b0, -1, 0, 0, 12, res);
    end

    // Reset while round 7 is executing.
    bus12.in_0 = rand384();
    bus12.in_1 = bus12.in_0 ^ fixed_state;
    for (int k = 0; k < 7; k++) begin
      bus12.in_valid  = (k == 0);
      bus12.rnd_valid = 1'b1;
      bus12.rnd       = rand384();
      @(posedge clk); #1;
    end
    bus12.in_valid = 1'b0;
    @(negedge clk);
    check_output("mid/busy", bus12.busy, 1);
    check_output("mid/rc", u_dut12.rc_q, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst/state", u_dut12.state_q, IDLE);
    check_output("mid_rst/rc", u_dut12.rc_q, 0);
    check_output("mid_rst/out_valid", bus12.out_valid, 0);
    check_output("mid_rst/busy", bus12.busy, 0);
    check_output("mid_rst/round_reg", rd_out_0_12, '0);
    @(posedge clk); #1;
    s0 = rand384();
    apply_stimulus("after_rst", s0, s0 ^ fixed_state, 1'b0, -1, 0, 0, 12, res);

    // Six-round instance: constants come from the tail of the table.
    lat6 = -1;
    s0 = rand384();
    bus6.in_0 = s0;
    bus6.in_1 = s0 ^ fixed_state;
    for (int k = 0; k < 8; k++) begin
      bus6.in_valid  = (k == 0);
      bus6.rnd_valid = 1'b1;
      bus6.rnd       = rand384();
      @(negedge clk);
      check_output("n6/out_valid", bus6.out_valid, (k == 6));
      if (k < 6) begin
        check_output("n6/rconst", rd_rconst_6, rc_ref[6+k]);
        check_output("n6/rnd_ready", bus6.rnd_ready, 1);
      end else begin
        check_output("n6/rconst_done", rd_rconst_6, 0);
      end
      if (bus6.out_valid && lat6 < 0) lat6 = k;
      if (k == 6) begin
        check_output("n6/result", bus6.out_0 ^ bus6.out_1, perm(fixed_state, 6));
        break;
      end
      @(posedge clk); #1;
    end
    check_output("n6/latency", lat6, 6);
    bus6.out_ready = 1'b1;
    @(posedge clk); #1;
    bus6.out_ready = 1'b0;
    @(negedge clk);
    check_output("n6/release", bus6.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xoodoo_perm_sca.md
# xoodoo_perm_sca

Sequencing controller for the first-order DOM-masked Xoodoo permutation. It sits directly upstream of the masked round datapath (`xoodoo_round_SCA`) and owns the permutation loop:
- accepts a two-share 384-bit state from the Xoodyak mode logic;
- drives the round datapath once per round, with the correct round constant and fresh 384-bit randomness;
- feeds the registered round output back as the next round's input;
- presents the permuted two-share state back upstream.

The round datapath register is the only state register. This block adds no 768-bit storage.

## Interface
Parameters:
- `NROUNDS`, default 12: rounds per permutation. Legal range 1..12. The last `NROUNDS` entries of the constant table are used.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream offers a state.
- `in_ready`  out  1  state accepted this cycle when high together with `in_valid`.
- `in_0`, `in_1`  in  384 each  input shares. Must be stable only in the handshake cycle.
- `rnd_valid`  in  1  PRNG has 384 fresh bits on `rnd`.
- `rnd_ready`  out  1  randomness consumed this cycle.
- `rnd`  in  384  fresh randomness.
- `out_valid`  out  1  permuted state available.
- `out_ready`  in  1  upstream takes the result.
- `out_0`, `out_1`  out  384 each  permuted shares. Direct pass of the round outputs.
- `busy`  out  1  high in ROUND or DONE.
- `rd_in_0`, `rd_in_1`  out  384 each  round datapath input shares.
- `rd_rdi`  out  384  round datapath randomness, equal to `rnd`.
- `rd_rdi_en`  out  1  round datapath register enable.
- `rd_rconst`  out  32  round constant.
- `rd_out_0`, `rd_out_1`  in  384 each  round datapath registered outputs.

## Operation
- State machine states: IDLE, ROUND, DONE. Round counter `rc` is 4 bits and counts 0..NROUNDS-1.
- IDLE:
  - `in_ready = rnd_valid`.
  - On `in_valid & in_ready`:
    - `rd_in_* = in_*`, `rd_rdi_en = 1`, `rnd_ready = 1`, `rd_rconst = RC[12-NROUNDS]`.
    - `rc <= 1`.
    - Next state is DONE if `NROUNDS == 1`, else ROUND.
- ROUND:
  - `rd_in_* = rd_out_*` (feedback); `rd_rdi_en = rnd_ready = rnd_valid`; `rd_rconst = RC[12-NROUNDS+rc]`.
  - When `rnd_valid` is low, the state stalls: `rc` holds and the round register holds.
  - When `rnd_valid` is high, `rc` increments. When `rc == NROUNDS-1`, the state goes to DONE and `rc <= 0`.
- DONE:
  - `out_valid = 1`, `rd_rdi_en = 0`. The result stays stable until `out_ready`.
  - On `out_ready`, go to IDLE. `in_ready` stays 0 in DONE, so there is no same-cycle restart.
- `rd_rconst = 0` whenever `rd_rdi_en = 0`.
- `rd_in_*` select `in_*` only in IDLE, and `rd_out_*` otherwise.
- Round constant table, index 0..11: 0x058, 0x038, 0x3C0, 0x0D0, 0x120, 0x014, 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012. Constants are zero-extended to 32 bits.
- Randomness is never reused. Each `rnd_ready` pulse consumes exactly one `rnd` word, and exactly NROUNDS words are consumed per permutation.
- Shares are never recombined inside this block.

## Timing
- Reset values: state IDLE, `rc = 0`, `in_ready = 0` until the first non-reset cycle, `out_valid = 0`, `busy = 0`, `rnd_ready = 0`, `rd_rdi_en = 0`, `rd_rconst = 0`.
- With no stalls, round 0 executes in handshake cycle t, and rounds 1..NROUNDS-1 execute in cycles t+1..t+NROUNDS-1.
- `out_valid` rises in cycle t+NROUNDS. Latency is NROUNDS cycles plus one cycle per `rnd_valid = 0` cycle in ROUND.
- All control outputs are combinational from the state, `rc`, and the valid inputs. Only the state and `rc` are registered.
- A reset in mid-permutation returns the block to IDLE on the next edge and drops `out_valid`. The round datapath shares the same `rst`, so its register is zeroed too.
- `rnd_valid` low in IDLE while `in_valid` is high: no handshake, and nothing changes.

## Structure
- Package `xoodoo_sca_pkg` holds:
  - state enum (IDLE/ROUND/DONE);
  - `NROUNDS_MAX = 12`;
  - the 12-entry constant table;
  - width constants (384 state bits, 32 lane bits).
- Sub-module `xoodoo_rc_rom`: combinational 4-bit index to 32-bit constant.
- The round datapath is instantiated alongside the controller by the parent, not inside it.

## Test plan
- Zero state, with zero shares and `rnd` tied to 0 and always valid, NROUNDS=12:
  - `out_valid` asserts exactly 12 cycles after the handshake;
  - `out_0 ^ out_1` equals the golden Xoodoo[12] of all-zero.
- Observed `rd_rconst` sequence, no stalls, NROUNDS=12: 0x058, 0x038, …, 0x012, then 0 in DONE. With NROUNDS=6 the sequence is 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012.
- Random shares of a fixed state with random `rnd`:
  - the recombined output matches the golden model for 100 vectors;
  - `rnd_ready` pulses exactly 12 times per permutation.
- `rnd_valid` deasserted for 3 cycles during round 5:
  - `rc` and `rd_out_*` hold;
  - latency is 15 cycles;
  - the result is unchanged versus the no-stall run.
- Hold `out_ready` low for 10 cycles in DONE:
  - `out_*` remain stable;
  - `in_ready` stays 0;
  - after the `out_ready` pulse the block is in IDLE and accepts a new state.
- Assert `rst` at round 7:
  - next cycle: IDLE, `out_valid = 0`, `rc = 0`;
  - a subsequent permutation completes correctly.
